// File: rtl/hdlbc_pkg.sv
// Shared HDLBC definitions: block width, engine FSM states and the
// forward / inverse 64-bit P-layer wiring. Bit 0 of a block is the MSB.
package hdlbc_pkg;

  localparam int BLOCK_W = 64;

  typedef logic [0:BLOCK_W-1] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward P: row r = o/8, column c = o%8,
  // res[8r+c] = st[8(7-c)+s(r)], s(r) = 2r+1 (r<4) or 2(r-4) (r>=4).
  function automatic block_t pbox_fwd(input block_t st);
    block_t res;
    int     r;
    int     c;
    int     s;
    res = '0;
    for (int o = 0; o < BLOCK_W; o++) begin
      r = o / 8;
      c = o % 8;
      s = (r < 4) ? (2 * r + 1) : (2 * (r - 4));
      res[o] = st[8 * (7 - c) + s];
    end
    return res;
  endfunction

  // Inverse P: row a = i/8, column b = i%8,
  // x[8a+b] = y[8q(b)+(7-a)], q(b) = (b-1)/2 (odd b) or b/2+4 (even b).
  function automatic block_t pbox_inv(input block_t y);
    block_t x;
    int     a;
    int     b;
    int     q;
    x = '0;
    for (int i = 0; i < BLOCK_W; i++) begin
      a = i / 8;
      b = i % 8;
      q = (b % 2 == 1) ? ((b - 1) / 2) : (b / 2 + 4);
      x[i] = y[8 * q + (7 - a)];
    end
    return x;
  endfunction

endpackage

// File: rtl/hdlbc_pbox_inv.sv
// Purely combinational inverse HDLBC P-layer, used by the decryption path.
module hdlbc_pbox_inv
  import hdlbc_pkg::*;
(
  input  logic [0:BLOCK_W-1] i_data,
  output logic [0:BLOCK_W-1] o_data
);

  assign o_data = pbox_inv(i_data);

endmodule

// File: rtl/hdlbc_pbox_iter.sv
// Iterated HDLBC P-layer engine: applies forward or inverse P k times,
// one application per clock, behind valid/ready handshakes on both sides.
module hdlbc_pbox_iter
  import hdlbc_pkg::*;
#(
  parameter int ROUNDS_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:BLOCK_W-1]  in_data,
  input  logic [ROUNDS_W-1:0] in_rounds,
  input  logic                in_dir,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:BLOCK_W-1]  out_data,
  output logic                busy
);

  localparam logic [ROUNDS_W-1:0] CNT_ONE = ROUNDS_W'(1);

  state_e              r_fsm;
  state_e              w_fsm_nxt;
  block_t              r_state;
  logic [ROUNDS_W-1:0] r_cnt;
  logic                r_dir;
  block_t              w_fwd;
  block_t              w_inv;
  block_t              w_perm;

  // Both directions are computed from the state register; r_dir selects one.
  assign w_fwd = pbox_fwd(r_state);

  hdlbc_pbox_inv u_pbox_inv (
    .i_data (r_state),
    .o_data (w_inv)
  );

  assign w_perm = r_dir ? w_inv : w_fwd;

  // FSM state register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, wait for out_ready in DONE.
  // NOTE: the default assignment first guarantees no latch on any path.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE: begin
        if (in_valid) begin
          w_fsm_nxt = (in_rounds == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == CNT_ONE) begin
          w_fsm_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Datapath: load on acceptance, permute and decrement while BUSY, hold otherwise.
  // NOTE: the block register is reset too, because out_data must read zero
  // after reset rather than whatever the previous operation left behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= in_data;
            r_cnt   <= in_rounds;
            r_dir   <= in_dir;
          end
        end
        BUSY: begin
          r_state <= w_perm;
          r_cnt   <= r_cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags depend only on the FSM state and rst_n.
  assign in_ready  = rst_n && (r_fsm == IDLE);
  assign busy      = (r_fsm == BUSY) || (r_fsm == DONE);
  assign out_valid = (r_fsm == DONE);
  assign out_data  = r_state;

endmodule

// File: tb/tb_hdlbc_pbox_iter.sv
// Self-checking bench for hdlbc_pbox_iter: directed cases plus randomized
// requests compared against a table-driven permutation model.
module tb_hdlbc_pbox_iter;

  localparam int ROUNDS_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [0:63]         in_data = '0;
  logic [ROUNDS_W-1:0] in_rounds = '0;
  logic                in_dir = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [0:63]         out_data;
  logic                busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Source-bit tables: result bit o (0 = MSB) takes input bit map[o].
  int fwd_map[64];
  int inv_map[64];

  always #5 clk = ~clk;

  hdlbc_pbox_iter #(.ROUNDS_W(ROUNDS_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rounds (in_rounds),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Forward table from the row/column rule; the inverse table is obtained
  // by inverting the forward table, independent of the inverse formula.
  task automatic build_maps();
    int r;
    int c;
    int s;
    for (int o = 0; o < 64; o++) begin
      r = o / 8;
      c = o % 8;
      s = (r < 4) ? (2 * r + 1) : (2 * (r - 4));
      fwd_map[o] = 8 * (7 - c) + s;
    end
    for (int o = 0; o < 64; o++) inv_map[fwd_map[o]] = o;
  endtask

  function automatic logic [63:0] model(input logic [63:0] v, input bit dir, input int k);
    logic [63:0] cur;
    logic [63:0] nxt;
    cur = v;
    for (int it = 0; it < k; it++) begin
      nxt = '0;
      for (int o = 0; o < 64; o++)
        nxt[63 - o] = cur[63 - (dir ? inv_map[o] : fwd_map[o])];
      cur = nxt;
    end
    return cur;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request/response; stall = cycles of out_ready low after out_valid,
  // noise = spurious in_valid pulses while the engine is occupied.
  task automatic run_req(input logic [63:0] d, input int k, input bit dir,
                         input int stall, input bit noise, output logic [63:0] res);
    int          n;
    logic [63:0] exp;
    exp = model(d, dir, k);
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_rounds = k[ROUNDS_W-1:0];
    in_dir    = dir;
    out_ready = 1'b0;
    step();
    in_valid  = 1'b0;
    in_data   = {$urandom, $urandom};
    in_rounds = ROUNDS_W'($urandom);
    in_dir    = 1'($urandom);
    check("ready_low_after_accept", {63'd0, in_ready}, 64'd0);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      if (noise) in_valid = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(k));
    check("out_data", out_data, exp);
    res = out_data;
    for (int i = 0; i < stall; i++) begin
      if (noise) in_valid = 1'($urandom_range(0, 1));
      step();
      check("hold_data", out_data, exp);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", {63'd0, out_valid}, 64'd0);
    check("ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] res2;
    logic [63:0] d;
    int          k;
    bit          dir;
    bit          saw_valid;

    build_maps();

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    step();
    check("rst_release_ready", {63'd0, in_ready}, 64'd1);

    // Single-bit directed vectors.
    run_req(64'h8000_0000_0000_0000, 1, 1'b1, 0, 1'b0, res);
    check("inv_bit0", res, 64'h0000_0000_0000_0040);
    run_req(64'h0000_0000_0100_0000, 1, 1'b1, 0, 1'b0, res);
    check("inv_bit39", res, 64'h8000_0000_0000_0000);
    run_req(64'h8000_0000_0000_0000, 1, 1'b0, 0, 1'b0, res);
    check("fwd_bit0", res, 64'h0000_0000_0100_0000);

    // Round trips, k=1 and k=15.
    run_req(64'h0123_4567_89AB_CDEF, 1, 1'b0, 0, 1'b0, res);
    run_req(res, 1, 1'b1, 0, 1'b0, res2);
    check("roundtrip_k1", res2, 64'h0123_4567_89AB_CDEF);
    run_req(64'h0123_4567_89AB_CDEF, 15, 1'b0, 0, 1'b0, res);
    run_req(res, 15, 1'b1, 0, 1'b0, res2);
    check("roundtrip_k15", res2, 64'h0123_4567_89AB_CDEF);

    // k=0 passthrough.
    run_req(64'hDEAD_BEEF_0BAD_F00D, 0, 1'b1, 0, 1'b0, res);
    check("k0_passthrough", res, 64'hDEAD_BEEF_0BAD_F00D);

    // Backpressure with spurious in_valid pulses.
    run_req(64'hA5A5_0F0F_3C3C_9696, 3, 1'b0, 5, 1'b1, res);

    // Reset in the middle of a k=10 operation.
    in_valid  = 1'b1;
    in_data   = 64'hFEDC_BA98_7654_3210;
    in_rounds = 4'd10;
    in_dir    = 1'b1;
    step();
    in_valid = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      saw_valid = saw_valid | out_valid;
    end
    rst_n = 1'b0;
    step();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    step();
    check("midrst_ready_after", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 14; i++) begin
      step();
      saw_valid = saw_valid | out_valid;
    end
    check("midrst_no_valid", {63'd0, saw_valid}, 64'd0);
    run_req(64'h0011_2233_4455_6677, 10, 1'b1, 0, 1'b0, res);

    // Randomized requests.
    for (int i = 0; i < 1000; i++) begin
      d   = {$urandom, $urandom};
      k   = $urandom_range(0, 15);
      dir = 1'($urandom_range(0, 1));
      run_req(d, k, dir, $urandom_range(0, 2), 1'($urandom_range(0, 1)), res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hdlbc_pbox_iter.md
# hdlbc_pbox_iter

HDLBC P-layer engine with a valid/ready handshake. It applies the forward or inverse 64-bit HDLBC bit permutation k times (k = 0..15), one application per clock. The decryption datapath uses it to undo the P-layer (inverse direction). Verification uses it for forward/inverse round-trip checks against the encryption path.

## Interface
Parameters:
- ROUNDS_W, 4, width of the iteration count; max k = 2**ROUNDS_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept; high only in IDLE and while rst_n=1.
- in_data  in  [0:63]  block; bit 0 is MSB.
- in_rounds  in  ROUNDS_W  number of permutation applications k.
- in_dir  in  1  1 = inverse P, 0 = forward P.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_data  out  [0:63]  result block.
- busy  out  1  high in BUSY or DONE.

## Operation
- Forward P, with row r = o/8 and column c = o%8: res[8r+c] = state[8(7-c)+s(r)], where s(r) = 2r+1 for r<4 and s(r) = 2(r-4) for r≥4.
- Inverse P, with row a = i/8 and column b = i%8: x[8a+b] = y[8·q(b)+(7-a)], where q(b) = (b-1)/2 for odd b and q(b) = b/2+4 for even b.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_data into the state register;
  - latch in_dir into dir_q;
  - set cnt := in_rounds;
  - next state is DONE if in_rounds==0, otherwise BUSY.
- BUSY: each cycle, state := P_dir(state) and cnt := cnt-1. When cnt==1, the next state is DONE.
- DONE: out_valid=1 and out_data=state. On out_ready the next state is IDLE.
- in_ready is low in BUSY and DONE. Requests are not queued. in_valid is ignored outside IDLE.
- in_dir and in_rounds are sampled only at acceptance. Later changes have no effect on the operation in flight.
- cnt is ROUNDS_W bits wide and never wraps: BUSY is never entered with cnt=0.
- out_data is registered and always equals the state register. It is only meaningful while out_valid=1.
- Reset (rst_n=0 at a rising edge), including mid-BUSY or in DONE with a pending result:
  - state → IDLE;
  - cnt, dir_q, state register and out_data → 0;
  - out_valid=0, busy=0, and in_ready=0 while rst_n=0;
  - any in-flight result is discarded.

## Timing
- Accept edge E0. out_valid is first high in the cycle after edge E0+k: k=0 gives 1 cycle of latency, k=15 gives 16.
- Result is held stable while out_valid && !out_ready, for unbounded backpressure.
- Handshake out at edge Ed returns to IDLE. in_ready is high the cycle after Ed.
- Minimum spacing between acceptances is k+2 cycles.
- No combinational path from in_* to out_*. in_ready and busy depend only on FSM state and rst_n.
- Reset values: out_valid=0, out_data=64'h0, busy=0, in_ready=0 while in reset and 1 the cycle after release.

## Structure
- Package hdlbc_pkg:
  - BLOCK_W=64;
  - FSM enum {IDLE, BUSY, DONE};
  - pure functions pbox_fwd and pbox_inv (64-bit wiring as above), shared with the encryption path and the testbench model.
- Sub-module hdlbc_pbox_inv: purely combinational inverse permutation, instantiated alongside the existing forward P-layer.
- Engine top: a 2:1 direction mux in front of the state register, plus the FSM and counter.

## Test plan
- Inverse, single bit: dir=1, k=1, in=64'h8000_0000_0000_0000 → out=64'h0000_0000_0000_0040, out_valid 2 cycles after handshake.
- Inverse, other bit: dir=1, k=1, in=64'h0000_0000_0100_0000 → out=64'h8000_0000_0000_0000. Forward of 64'h8000_0000_0000_0000 with k=1 → 64'h0000_0000_0100_0000.
- Round trip: forward k=1 on 64'h0123_4567_89AB_CDEF, then feed the result with inverse k=1 → 64'h0123_4567_89AB_CDEF. Repeat with k=15 both ways → identity. Random 1000 vectors, k=0..15, checked against the package functions.
- k=0 passthrough: in=64'hDEAD_BEEF_0BAD_F00D → same value with out_valid on the next cycle; in_ready low exactly 1 cycle.
- Backpressure: k=3, out_ready low for 5 cycles after out_valid → out_data stable, in_ready=0, and in_valid pulses during BUSY/DONE are ignored. Single handshake, then IDLE.
- Reset mid-BUSY: k=10, assert rst_n=0 at cycle 4 → out_valid never rises, out_data=0, in_ready=1 one cycle after release. The next request completes normally.
